// File: rtl/sarb_pkg.sv
// ============================================================================
// sarb_pkg : shared types and strobe constants for the SRAM arbiter
// Rev 1.0
// ============================================================================
`default_nettype none

package sarb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } state_t;

   typedef enum logic {
      PORT_I = 1'b0,
      PORT_D = 1'b1
   } port_t;

   localparam logic STROBE_OFF = 1'b1;
   localparam logic STROBE_ON  = 1'b0;

   // Active-low byte-lane strobes from active-high byte enables.
   function automatic logic [1:0] lane_strobes(input logic [1:0] be);
      return ~be;
   endfunction

endpackage

`default_nettype wire

// File: rtl/sarb_rr2.sv
// ============================================================================
// sarb_rr2 : two-way round-robin picker; bit0 = fetch, bit1 = data
// Rev 1.0
// ============================================================================
`default_nettype none

module sarb_rr2 (
   input  logic [1:0] req,
   input  logic       last,
   output logic [1:0] grant
);

   // On a tie, the port that did not win last time takes the grant.
   always_comb begin
      grant = 2'b00;
      case (req)
         2'b01:   grant = 2'b01;
         2'b10:   grant = 2'b10;
         2'b11:   grant = last ? 2'b01 : 2'b10;
         default: grant = 2'b00;
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/sram_arbiter.sv
// ============================================================================
// sram_arbiter : shares one async SRAM between fetch (I) and data (D) ports
// Rev 1.0
// ============================================================================
`default_nettype none

module sram_arbiter
   import sarb_pkg::*;
#(
   parameter int ADDR_W     = 18,
   parameter int DATA_W     = 16,
   parameter int ACC_CYCLES = 2
) (
   input  logic              sarb_clk_i,
   input  logic              sarb_rstn_i,
   input  logic              sarb_iReq_i,
   input  logic [ADDR_W-1:0] sarb_iAddr_i,
   output logic              sarb_iAck_o,
   output logic [DATA_W-1:0] sarb_iData_o,
   input  logic              sarb_dReq_i,
   input  logic              sarb_dWr_i,
   input  logic [1:0]        sarb_dBe_i,
   input  logic [ADDR_W-1:0] sarb_dAddr_i,
   input  logic [DATA_W-1:0] sarb_dWdata_i,
   output logic              sarb_dAck_o,
   output logic [DATA_W-1:0] sarb_dRdata_o,
   output logic [ADDR_W-1:0] sarb_sramAddr_o,
   output logic [DATA_W-1:0] sarb_sramDq_o,
   output logic              sarb_sramDqOe_o,
   input  logic [DATA_W-1:0] sarb_sramDq_i,
   output logic              sarb_sramCeN_o,
   output logic              sarb_sramWeN_o,
   output logic              sarb_sramOeN_o,
   output logic              sarb_sramUbN_o,
   output logic              sarb_sramLbN_o
);

   localparam int CNT_W = (ACC_CYCLES > 1) ? $clog2(ACC_CYCLES) : 1;

   state_t           state;
   port_t            cur_port;
   port_t            rr_last;
   logic             cur_wr;
   logic [CNT_W-1:0] cnt;
   logic [1:0]       grant;
   logic [1:0]       be_n;

   sarb_rr2 u_rr2 (
      .req   ({sarb_dReq_i, sarb_iReq_i}),
      .last  (rr_last == PORT_D),
      .grant (grant)
   );

   assign be_n = lane_strobes(sarb_dBe_i);

   always_ff @(posedge sarb_clk_i) begin
      if (!sarb_rstn_i) begin
         state           <= IDLE;
         cur_port        <= PORT_I;
         rr_last         <= PORT_D;
         cur_wr          <= 1'b0;
         cnt             <= '0;
         sarb_iAck_o     <= 1'b0;
         sarb_dAck_o     <= 1'b0;
         sarb_iData_o    <= '0;
         sarb_dRdata_o   <= '0;
         sarb_sramAddr_o <= '0;
         sarb_sramDq_o   <= '0;
         sarb_sramDqOe_o <= 1'b0;
         sarb_sramCeN_o  <= STROBE_OFF;
         sarb_sramWeN_o  <= STROBE_OFF;
         sarb_sramOeN_o  <= STROBE_OFF;
         sarb_sramUbN_o  <= STROBE_OFF;
         sarb_sramLbN_o  <= STROBE_OFF;
      end else begin
         sarb_iAck_o <= 1'b0;
         sarb_dAck_o <= 1'b0;
         case (state)
            IDLE: begin
               if (grant != 2'b00) begin
                  cnt            <= CNT_W'(ACC_CYCLES - 1);
                  state          <= ACCESS;
                  sarb_sramCeN_o <= STROBE_ON;
                  if (grant[0]) begin
                     cur_port        <= PORT_I;
                     rr_last         <= PORT_I;
                     cur_wr          <= 1'b0;
                     sarb_sramAddr_o <= sarb_iAddr_i;
                     sarb_sramWeN_o  <= STROBE_OFF;
                     sarb_sramOeN_o  <= STROBE_ON;
                     sarb_sramUbN_o  <= STROBE_ON;
                     sarb_sramLbN_o  <= STROBE_ON;
                     sarb_sramDqOe_o <= 1'b0;
                  end else begin
                     cur_port        <= PORT_D;
                     rr_last         <= PORT_D;
                     cur_wr          <= sarb_dWr_i;
                     sarb_sramAddr_o <= sarb_dAddr_i;
                     sarb_sramDq_o   <= sarb_dWdata_i;
                     if (sarb_dWr_i) begin
                        sarb_sramWeN_o  <= STROBE_ON;
                        sarb_sramOeN_o  <= STROBE_OFF;
                        sarb_sramUbN_o  <= be_n[1];
                        sarb_sramLbN_o  <= be_n[0];
                        sarb_sramDqOe_o <= 1'b1;
                     end else begin
                        sarb_sramWeN_o  <= STROBE_OFF;
                        sarb_sramOeN_o  <= STROBE_ON;
                        sarb_sramUbN_o  <= STROBE_ON;
                        sarb_sramLbN_o  <= STROBE_ON;
                        sarb_sramDqOe_o <= 1'b0;
                     end
                  end
               end
            end
            ACCESS: begin
               if (cnt == '0) begin
                  // Releasing every strobe together gives the turnaround gap in DONE.
                  state           <= DONE;
                  sarb_sramCeN_o  <= STROBE_OFF;
                  sarb_sramWeN_o  <= STROBE_OFF;
                  sarb_sramOeN_o  <= STROBE_OFF;
                  sarb_sramUbN_o  <= STROBE_OFF;
                  sarb_sramLbN_o  <= STROBE_OFF;
                  sarb_sramDqOe_o <= 1'b0;
                  if (cur_port == PORT_I) begin
                     sarb_iAck_o  <= 1'b1;
                     sarb_iData_o <= sarb_sramDq_i;
                  end else begin
                     sarb_dAck_o <= 1'b1;
                     if (!cur_wr) begin
                        sarb_dRdata_o <= sarb_sramDq_i;
                     end
                  end
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_sram_arbiter.sv
// ============================================================================
// tb_sram_arbiter : directed bench with a byte-lane async SRAM model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_sram_arbiter;

   localparam int ADDR_W = 18;
   localparam int DATA_W = 16;
   localparam int ACC    = 2;
   // Edges from request assertion until ack is visible: grant edge + ACC.
   localparam int LAT    = ACC + 1;

   logic              clk = 1'b0;
   logic              rstn = 1'b0;
   logic              i_req = 1'b0;
   logic [ADDR_W-1:0] i_addr = '0;
   logic              i_ack;
   logic [DATA_W-1:0] i_data;
   logic              d_req = 1'b0;
   logic              d_wr = 1'b0;
   logic [1:0]        d_be = 2'b00;
   logic [ADDR_W-1:0] d_addr = '0;
   logic [DATA_W-1:0] d_wdata = '0;
   logic              d_ack;
   logic [DATA_W-1:0] d_rdata;
   logic [ADDR_W-1:0] sram_addr;
   logic [DATA_W-1:0] dq_o;
   logic              dq_oe;
   logic [DATA_W-1:0] dq_i;
   logic              ce_n, we_n, oe_n, ub_n, lb_n;

   int vectors = 0;
   int miscompares = 0;
   int overlap_cnt = 0;

   logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
   logic              pl_en = 1'b0;
   logic [ADDR_W-1:0] pl_addr = '0;
   logic [DATA_W-1:0] pl_data = '0;

   always #5 clk = ~clk;

   sram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ACC_CYCLES(ACC)) dut (
      .sarb_clk_i      (clk),
      .sarb_rstn_i     (rstn),
      .sarb_iReq_i     (i_req),
      .sarb_iAddr_i    (i_addr),
      .sarb_iAck_o     (i_ack),
      .sarb_iData_o    (i_data),
      .sarb_dReq_i     (d_req),
      .sarb_dWr_i      (d_wr),
      .sarb_dBe_i      (d_be),
      .sarb_dAddr_i    (d_addr),
      .sarb_dWdata_i   (d_wdata),
      .sarb_dAck_o     (d_ack),
      .sarb_dRdata_o   (d_rdata),
      .sarb_sramAddr_o (sram_addr),
      .sarb_sramDq_o   (dq_o),
      .sarb_sramDqOe_o (dq_oe),
      .sarb_sramDq_i   (dq_i),
      .sarb_sramCeN_o  (ce_n),
      .sarb_sramWeN_o  (we_n),
      .sarb_sramOeN_o  (oe_n),
      .sarb_sramUbN_o  (ub_n),
      .sarb_sramLbN_o  (lb_n)
   );

   // SRAM read path: the chassis loops driven DQ back; otherwise the chip drives it.
   always_comb begin
      dq_i = 16'h0000;
      if (dq_oe) dq_i = dq_o;
      else if (!ce_n && !oe_n) dq_i = mem[sram_addr];
   end

   always @(posedge clk) begin
      if (pl_en) begin
         mem[pl_addr] <= pl_data;
      end else if (!ce_n && !we_n) begin
         if (!ub_n) mem[sram_addr][15:8] <= dq_o[15:8];
         if (!lb_n) mem[sram_addr][7:0]  <= dq_o[7:0];
      end
   end

   always @(negedge clk) begin
      if (dq_oe && !oe_n) overlap_cnt++;
   end

   task automatic preload(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] v);
      @(posedge clk); #1;
      pl_en = 1'b1; pl_addr = a; pl_data = v;
      @(posedge clk); #1;
      pl_en = 1'b0;
   endtask

   // Issues one request, waits (bounded) for its ack, drops req the cycle after.
   task automatic run_access(input logic port_d, input logic wr, input logic [1:0] be,
                             input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] wd,
                             output int lat, output int oe_lo, output int ub_lo,
                             output int lb_lo, output logic [DATA_W-1:0] rd,
                             output logic other_ack);
      logic done;
      @(posedge clk); #1;
      if (port_d) begin
         d_req = 1'b1; d_wr = wr; d_be = be; d_addr = a; d_wdata = wd;
      end else begin
         i_req = 1'b1; i_addr = a;
      end
      lat = 0; oe_lo = 0; ub_lo = 0; lb_lo = 0; other_ack = 1'b0; done = 1'b0;
      while (!done && lat < 20) begin
         @(posedge clk); #1;
         lat++;
         if (!oe_n) oe_lo++;
         if (!ub_n) ub_lo++;
         if (!lb_n) lb_lo++;
         if (port_d ? d_ack : i_ack) done = 1'b1;
         if (port_d ? i_ack : d_ack) other_ack = 1'b1;
      end
      rd = port_d ? d_rdata : i_data;
      @(posedge clk); #1;
      i_req = 1'b0; d_req = 1'b0;
      if (!done) lat = -1;
   endtask

   task automatic test_reset();
      int lat;
      logic got;
      rstn = 1'b0; i_req = 1'b1; d_req = 1'b1; i_addr = 18'h00010; d_addr = 18'h00020;
      for (int k = 0; k < 3; k++) begin
         @(posedge clk); #1;
         vectors++;
         if ({i_ack, d_ack, ce_n, we_n, oe_n, ub_n, lb_n, dq_oe} !== 8'b00_11111_0) begin
            miscompares++;
            $display("FAIL reset_state edge %0d: got %b expected 00111110", k,
                     {i_ack, d_ack, ce_n, we_n, oe_n, ub_n, lb_n, dq_oe});
         end
      end
      vectors++;
      if (sram_addr !== '0 || i_data !== '0 || d_rdata !== '0) begin
         miscompares++;
         $display("FAIL reset_data: addr %h idata %h drdata %h expected all zero",
                  sram_addr, i_data, d_rdata);
      end
      rstn = 1'b1;
      lat = 0; got = 1'b0;
      while (!got && lat < 20) begin
         @(posedge clk); #1;
         lat++;
         if (i_ack || d_ack) got = 1'b1;
      end
      vectors++;
      if (!got || i_ack !== 1'b1 || d_ack !== 1'b0 || lat != LAT) begin
         miscompares++;
         $display("FAIL reset_first_grant: iack %b dack %b lat %0d expected iack 1 dack 0 lat %0d",
                  i_ack, d_ack, lat, LAT);
      end
      @(posedge clk); #1;
      i_req = 1'b0; d_req = 1'b0;
   endtask

   task automatic test_single_read();
      int lat, oe_lo, ub_lo, lb_lo;
      logic [DATA_W-1:0] rd;
      logic oth;
      preload(18'h00123, 16'hBEEF);
      run_access(1'b0, 1'b0, 2'b00, 18'h00123, 16'h0000, lat, oe_lo, ub_lo, lb_lo, rd, oth);
      vectors++;
      if (lat != LAT || oth) begin
         miscompares++;
         $display("FAIL read_latency: got %0d other_ack %b expected %0d other_ack 0", lat, oth, LAT);
      end
      vectors++;
      if (rd !== 16'hBEEF) begin
         miscompares++;
         $display("FAIL read_data: got %h expected BEEF", rd);
      end
      vectors++;
      if (oe_lo != ACC) begin
         miscompares++;
         $display("FAIL read_oe_width: got %0d expected %0d", oe_lo, ACC);
      end
   endtask

   task automatic test_byte_write();
      int lat, oe_lo, ub_lo, lb_lo;
      logic [DATA_W-1:0] rd;
      logic oth;
      preload(18'h3FFFF, 16'h1234);
      run_access(1'b1, 1'b1, 2'b10, 18'h3FFFF, 16'hAB00, lat, oe_lo, ub_lo, lb_lo, rd, oth);
      vectors++;
      if (lat != LAT) begin
         miscompares++;
         $display("FAIL write_latency: got %0d expected %0d", lat, LAT);
      end
      vectors++;
      if (mem[18'h3FFFF] !== 16'hAB34) begin
         miscompares++;
         $display("FAIL write_upper_mem: got %h expected AB34", mem[18'h3FFFF]);
      end
      vectors++;
      if (ub_lo != ACC || lb_lo != 0 || oe_lo != 0) begin
         miscompares++;
         $display("FAIL write_strobes: ub_lo %0d lb_lo %0d oe_lo %0d expected %0d 0 0",
                  ub_lo, lb_lo, oe_lo, ACC);
      end
      run_access(1'b1, 1'b1, 2'b01, 18'h3FFFF, 16'h77CD, lat, oe_lo, ub_lo, lb_lo, rd, oth);
      vectors++;
      if (mem[18'h3FFFF] !== 16'hABCD) begin
         miscompares++;
         $display("FAIL write_lower_mem: got %h expected ABCD", mem[18'h3FFFF]);
      end
      vectors++;
      if (i_data !== 16'hBEEF) begin
         miscompares++;
         $display("FAIL idata_hold: got %h expected BEEF", i_data);
      end
   endtask

   task automatic test_data_read_and_null_write();
      int lat, oe_lo, ub_lo, lb_lo;
      logic [DATA_W-1:0] rd;
      logic oth;
      run_access(1'b1, 1'b0, 2'b00, 18'h3FFFF, 16'h0000, lat, oe_lo, ub_lo, lb_lo, rd, oth);
      vectors++;
      if (rd !== 16'hABCD || lat != LAT) begin
         miscompares++;
         $display("FAIL d_read: data %h lat %0d expected ABCD lat %0d", rd, lat, LAT);
      end
      preload(18'h00005, 16'h5555);
      run_access(1'b1, 1'b1, 2'b00, 18'h00005, 16'hFFFF, lat, oe_lo, ub_lo, lb_lo, rd, oth);
      vectors++;
      if (lat != LAT || mem[18'h00005] !== 16'h5555 || ub_lo != 0 || lb_lo != 0) begin
         miscompares++;
         $display("FAIL null_write: lat %0d mem %h ub_lo %0d lb_lo %0d expected lat %0d mem 5555 0 0",
                  lat, mem[18'h00005], ub_lo, lb_lo, LAT);
      end
      vectors++;
      if (d_rdata !== 16'hABCD) begin
         miscompares++;
         $display("FAIL drdata_hold_after_write: got %h expected ABCD", d_rdata);
      end
   endtask

   // Last grant before this is D, so the first tie goes to I.
   task automatic test_contention();
      int cyc;
      int n;
      logic [DATA_W-1:0] exp_d;
      @(posedge clk); #1;
      i_req = 1'b1; i_addr = 18'h00123;
      d_req = 1'b1; d_wr = 1'b0; d_be = 2'b11; d_addr = 18'h3FFFF;
      cyc = 0; n = 0;
      while (n < 8 && cyc < 60) begin
         @(posedge clk); #1;
         cyc++;
         if (i_ack || d_ack) begin
            vectors++;
            if ({i_ack, d_ack} !== ((n % 2 == 0) ? 2'b10 : 2'b01) || cyc != LAT + 4 * n) begin
               miscompares++;
               $display("FAIL contention_order #%0d: iack %b dack %b cycle %0d expected %s at %0d",
                        n, i_ack, d_ack, cyc, (n % 2 == 0) ? "I" : "D", LAT + 4 * n);
            end
            exp_d = (n % 2 == 0) ? 16'hBEEF : 16'hABCD;
            vectors++;
            if (((n % 2 == 0) ? i_data : d_rdata) !== exp_d) begin
               miscompares++;
               $display("FAIL contention_data #%0d: got %h expected %h", n,
                        (n % 2 == 0) ? i_data : d_rdata, exp_d);
            end
            n++;
         end
      end
      vectors++;
      if (n != 8) begin
         miscompares++;
         $display("FAIL contention_count: got %0d acks expected 8", n);
      end
      @(posedge clk); #1;
      i_req = 1'b0; d_req = 1'b0;
   endtask

   task automatic test_abort();
      int lat, oe_lo, ub_lo, lb_lo;
      logic [DATA_W-1:0] rd;
      logic oth;
      logic seen_ack;
      @(posedge clk); #1;
      i_req = 1'b1; i_addr = 18'h00123;
      @(posedge clk); #1;
      vectors++;
      if (oe_n !== 1'b0) begin
         miscompares++;
         $display("FAIL abort_in_access: oe_n %b expected 0", oe_n);
      end
      rstn = 1'b0;
      @(posedge clk); #1;
      i_req = 1'b0;
      vectors++;
      if ({i_ack, d_ack, ce_n, we_n, oe_n, ub_n, lb_n, dq_oe} !== 8'b00_11111_0) begin
         miscompares++;
         $display("FAIL abort_state: got %b expected 00111110",
                  {i_ack, d_ack, ce_n, we_n, oe_n, ub_n, lb_n, dq_oe});
      end
      seen_ack = 1'b0;
      @(posedge clk); #1;
      if (i_ack || d_ack) seen_ack = 1'b1;
      rstn = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(posedge clk); #1;
         if (i_ack || d_ack) seen_ack = 1'b1;
      end
      vectors++;
      if (seen_ack) begin
         miscompares++;
         $display("FAIL abort_no_ack: got ack 1 expected 0");
      end
      run_access(1'b0, 1'b0, 2'b00, 18'h00123, 16'h0000, lat, oe_lo, ub_lo, lb_lo, rd, oth);
      vectors++;
      if (rd !== 16'hBEEF || lat != LAT || oe_lo != ACC) begin
         miscompares++;
         $display("FAIL abort_recover: data %h lat %0d oe_lo %0d expected BEEF %0d %0d",
                  rd, lat, oe_lo, LAT, ACC);
      end
   endtask

   task automatic test_bus_overlap();
      vectors++;
      if (overlap_cnt != 0) begin
         miscompares++;
         $display("FAIL dq_oe_overlap: got %0d cycles expected 0", overlap_cnt);
      end
   endtask

   initial begin
      test_reset();
      test_single_read();
      test_byte_write();
      test_data_read_and_null_write();
      test_contention();
      test_abort();
      test_bus_overlap();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1);
   end

endmodule

`default_nettype wire
